// File: rtl/cdb_wb_arbiter.sv
// Common data bus writeback arbiter: four per-source result FIFOs drained
// round-robin into one registered CDB beat per cycle.
module cdb_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int PHY_W  = 8,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [3:0]          req_valid,
  input  logic [4*PHY_W-1:0]  req_phy,
  input  logic [4*DATA_W-1:0] req_data,
  input  logic [4*PC_W-1:0]   req_pc,
  output logic [3:0]          req_ready,
  output logic                cdb_valid,
  output logic [PHY_W-1:0]    cdb_phy,
  output logic [DATA_W-1:0]   cdb_data,
  output logic [PC_W-1:0]     cdb_pc,
  output logic [1:0]          cdb_src,
  output logic                busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [3:0]             nonempty;
  logic [3:0]             push;
  logic [3:0]             pop;
  logic [3:0][PHY_W-1:0]  head_phy;
  logic [3:0][DATA_W-1:0] head_data;
  logic [3:0][PC_W-1:0]   head_pc;

  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [1:0] rr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fifo
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [CNT_W-1:0]  count_reg;
      logic [PHY_W-1:0]  phy_mem  [DEPTH];
      logic [DATA_W-1:0] data_mem [DEPTH];
      logic [PC_W-1:0]   pc_mem   [DEPTH];
      logic [PHY_W-1:0]  in_phy;
      logic              keep;

      assign in_phy        = req_phy[gi*PHY_W +: PHY_W];
      assign req_ready[gi] = rst && (count_reg < CNT_W'(DEPTH));
      assign push[gi]      = req_valid[gi] && req_ready[gi] && !flush;
      // Results targeting x0 complete the handshake but are never stored.
      assign keep          = push[gi] && (in_phy != '0);
      assign nonempty[gi]  = (count_reg != '0);
      assign pop[gi]       = grant_valid && (grant_idx == 2'(gi)) && !flush;
      assign head_phy[gi]  = phy_mem[rd_ptr_reg];
      assign head_data[gi] = data_mem[rd_ptr_reg];
      assign head_pc[gi]   = pc_mem[rd_ptr_reg];

      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (keep)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          if (pop[gi])
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          count_reg <= count_reg + CNT_W'(keep) - CNT_W'(pop[gi]);
        end
      end

      always_ff @(posedge clk) begin
        if (rst && keep) begin
          phy_mem[wr_ptr_reg]  <= in_phy;
          data_mem[wr_ptr_reg] <= req_data[gi*DATA_W +: DATA_W];
          pc_mem[wr_ptr_reg]   <= req_pc[gi*PC_W +: PC_W];
        end
      end
    end
  endgenerate

  // Highest scan offset first so the source nearest rr wins.
  always_comb begin
    logic [1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = rr_reg;
    idx         = rr_reg;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_reg + 2'(k);
      if (nonempty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_reg    <= '0;
      cdb_valid <= 1'b0;
      cdb_phy   <= '0;
      cdb_data  <= '0;
      cdb_pc    <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      rr_reg    <= '0;
      cdb_valid <= 1'b0;
    end else if (grant_valid) begin
      rr_reg    <= grant_idx + 2'd1;
      cdb_valid <= 1'b1;
      cdb_phy   <= head_phy[grant_idx];
      cdb_data  <= head_data[grant_idx];
      cdb_pc    <= head_pc[grant_idx];
      cdb_src   <= grant_idx;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

  assign busy = |nonempty;

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Directed bench for cdb_wb_arbiter: hand-computed CDB beats, ready and busy
// values across reset, round-robin, full FIFO, x0 drop, flush and reset.
module tb_cdb_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int PHY_W  = 8;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              flush;
  logic [3:0]        req_valid;
  logic [PHY_W-1:0]  phy_a  [4];
  logic [DATA_W-1:0] data_a [4];
  logic [PC_W-1:0]   pc_a   [4];
  logic [4*PHY_W-1:0]  req_phy;
  logic [4*DATA_W-1:0] req_data;
  logic [4*PC_W-1:0]   req_pc;
  logic [3:0]          req_ready;
  logic                cdb_valid;
  logic [PHY_W-1:0]    cdb_phy;
  logic [DATA_W-1:0]   cdb_data;
  logic [PC_W-1:0]     cdb_pc;
  logic [1:0]          cdb_src;
  logic                busy;

  assign req_phy  = {phy_a[3], phy_a[2], phy_a[1], phy_a[0]};
  assign req_data = {data_a[3], data_a[2], data_a[1], data_a[0]};
  assign req_pc   = {pc_a[3], pc_a[2], pc_a[1], pc_a[0]};

  cdb_wb_arbiter #(.DATA_W(DATA_W), .PHY_W(PHY_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_phy(req_phy), .req_data(req_data), .req_pc(req_pc),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_phy(cdb_phy),
    .cdb_data(cdb_data), .cdb_pc(cdb_pc), .cdb_src(cdb_src), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 4'b0000;
  endtask

  task automatic push(input int i, input logic [7:0] phy, input logic [31:0] data,
                      input logic [31:0] pc);
    req_valid[i] = 1'b1;
    phy_a[i]     = phy;
    data_a[i]    = data;
    pc_a[i]      = pc;
  endtask

  task automatic beat(input string tag, input int src, input logic [7:0] phy,
                      input logic [31:0] data, input logic [31:0] pc);
    check({tag, ".valid"}, 64'(cdb_valid), 64'd1);
    check({tag, ".src"},   64'(cdb_src),   64'(src));
    check({tag, ".phy"},   64'(cdb_phy),   64'(phy));
    check({tag, ".data"},  64'(cdb_data),  64'(data));
    check({tag, ".pc"},    64'(cdb_pc),    64'(pc));
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      phy_a[i] = '0; data_a[i] = '0; pc_a[i] = '0;
    end

    // Reset state
    step(); step();
    check("rst.valid", 64'(cdb_valid), 64'd0);
    check("rst.phy",   64'(cdb_phy),   64'd0);
    check("rst.data",  64'(cdb_data),  64'd0);
    check("rst.pc",    64'(cdb_pc),    64'd0);
    check("rst.src",   64'(cdb_src),   64'd0);
    check("rst.busy",  64'(busy),      64'd0);
    check("rst.ready", 64'(req_ready), 64'h0);
    rst = 1'b1;
    step();
    check("rst.ready_after", 64'(req_ready), 64'hf);

    // Single ALU result
    push(0, 8'd5, 32'h1234, 32'h40);
    step();
    idle();
    check("t1.pending_valid", 64'(cdb_valid), 64'd0);
    check("t1.busy", 64'(busy), 64'd1);
    step();
    beat("t1.beat", 0, 8'd5, 32'h1234, 32'h40);
    check("t1.busy_after", 64'(busy), 64'd0);
    step();
    check("t1.idle_valid", 64'(cdb_valid), 64'd0);
    check("t1.hold_data",  64'(cdb_data),  64'h1234);
    check("t1.hold_phy",   64'(cdb_phy),   64'd5);
    check("t1.hold_src",   64'(cdb_src),   64'd0);

    // rr is 1 here; a flush returns it to 0
    flush = 1'b1;
    step();
    flush = 1'b0;

    // All four sources push together
    for (int i = 0; i < 4; i++)
      push(i, 8'(8'h10 + i), 32'h200 + i, 32'h1200 + i);
    step();
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      beat($sformatf("t2.beat%0d", i), i, 8'(8'h10 + i), 32'h200 + i, 32'h1200 + i);
      if (i == 2) check("t2.busy_mid", 64'(busy), 64'd1);
    end
    check("t2.busy_end", 64'(busy), 64'd0);
    step();
    check("t2.idle_valid", 64'(cdb_valid), 64'd0);

    // Contended fill: DIV FIFO reaches full, third DIV result waits for ready
    for (int i = 0; i < 4; i++)
      push(i, 8'(8'h30 + i), 32'h300 + i, 32'h1300 + i);
    step();
    check("t3.ready_e1", 64'(req_ready), 64'hf);
    for (int i = 0; i < 4; i++)
      push(i, 8'(8'h40 + i), 32'h400 + i, 32'h1400 + i);
    step();
    idle();
    beat("t3.e2", 0, 8'h30, 32'h300, 32'h1300);
    check("t3.ready_e2", 64'(req_ready), 64'b0001);
    step();
    beat("t3.e3", 1, 8'h31, 32'h301, 32'h1301);
    check("t3.ready_e3", 64'(req_ready), 64'b0011);
    step();
    beat("t3.e4", 2, 8'h32, 32'h302, 32'h1302);
    check("t3.ready_e4", 64'(req_ready), 64'b0111);
    step();
    beat("t3.e5", 3, 8'h33, 32'h303, 32'h1303);
    check("t3.ready_e5", 64'(req_ready), 64'b1111);
    push(3, 8'h53, 32'h503, 32'h1503);
    step();
    idle();
    beat("t3.e6", 0, 8'h40, 32'h400, 32'h1400);
    check("t3.ready_e6", 64'(req_ready), 64'b0111);
    step();
    beat("t3.e7", 1, 8'h41, 32'h401, 32'h1401);
    step();
    beat("t3.e8", 2, 8'h42, 32'h402, 32'h1402);
    step();
    beat("t3.e9", 3, 8'h43, 32'h403, 32'h1403);
    step();
    beat("t3.e10", 3, 8'h53, 32'h503, 32'h1503);
    check("t3.busy_end", 64'(busy), 64'd0);
    step();
    check("t3.idle_valid", 64'(cdb_valid), 64'd0);

    // LOAD and MUL traffic alternates grants
    push(1, 8'h61, 32'h600, 32'h1600);
    push(2, 8'h71, 32'h700, 32'h1700);
    step();
    push(1, 8'h62, 32'h601, 32'h1601);
    push(2, 8'h72, 32'h701, 32'h1701);
    step();
    idle();
    beat("t4.b0", 1, 8'h61, 32'h600, 32'h1600);
    step();
    beat("t4.b1", 2, 8'h71, 32'h700, 32'h1700);
    step();
    beat("t4.b2", 1, 8'h62, 32'h601, 32'h1601);
    step();
    beat("t4.b3", 2, 8'h72, 32'h701, 32'h1701);
    step();
    check("t4.idle_valid", 64'(cdb_valid), 64'd0);

    // x0 destination: accepted, never stored or broadcast
    push(0, 8'h00, 32'hdead, 32'h1dea);
    check("t5.ready", 64'(req_ready[0]), 64'd1);
    step();
    idle();
    check("t5.busy", 64'(busy), 64'd0);
    check("t5.valid1", 64'(cdb_valid), 64'd0);
    step();
    check("t5.valid2", 64'(cdb_valid), 64'd0);
    check("t5.hold_data", 64'(cdb_data), 64'h701);

    // Flush with ALU/MUL buffered and a same-cycle LOAD push (rr=3 at start)
    push(0, 8'h81, 32'h900, 32'h1900);
    push(2, 8'h91, 32'ha00, 32'h1a00);
    step();
    push(0, 8'h82, 32'h901, 32'h1901);
    push(2, 8'h92, 32'ha01, 32'h1a01);
    step();
    idle();
    beat("t6.pre", 0, 8'h81, 32'h900, 32'h1900);
    push(1, 8'h70, 32'h800, 32'h1800);
    flush = 1'b1;
    check("t6.ready_flushcyc", 64'(req_ready), 64'b1011);
    step();
    idle();
    flush = 1'b0;
    check("t6.valid", 64'(cdb_valid), 64'd0);
    check("t6.busy", 64'(busy), 64'd0);
    check("t6.hold_data", 64'(cdb_data), 64'h900);
    step();
    check("t6.valid2", 64'(cdb_valid), 64'd0);
    check("t6.busy2", 64'(busy), 64'd0);
    push(0, 8'hb0, 32'hb00, 32'h1b00);
    push(3, 8'hb3, 32'hb03, 32'h1b03);
    step();
    idle();
    step();
    beat("t6.rr0_a", 0, 8'hb0, 32'hb00, 32'h1b00);
    step();
    beat("t6.rr0_b", 3, 8'hb3, 32'hb03, 32'h1b03);

    // Reset mid-operation drops the buffered result
    push(0, 8'h09, 32'hbbb, 32'h1bbb);
    step();
    idle();
    rst = 1'b0;
    step();
    check("t7.valid", 64'(cdb_valid), 64'd0);
    check("t7.data", 64'(cdb_data), 64'd0);
    check("t7.busy", 64'(busy), 64'd0);
    check("t7.ready", 64'(req_ready), 64'h0);
    rst = 1'b1;
    step();
    check("t7.valid2", 64'(cdb_valid), 64'd0);
    check("t7.busy2", 64'(busy), 64'd0);
    step();
    check("t7.valid3", 64'(cdb_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_wb_arbiter.md
Name: cdb_wb_arbiter

Overview:
- Shares the single common data bus (CDB) writeback path between the four execution sources: ALU, load, multiplier and divider.
- Each source's results are buffered in a small per-source FIFO. One result per cycle is granted round-robin and broadcast as a registered CDB beat.
- The CDB beat drives the physical register file write port, reservation-station wakeup and ROB completion.
- Sits between the EX/MEM result outputs and the physical register file / ROB.

Parameters:
DATA_W, 32, result data width
PHY_W, 8, physical register tag width
PC_W, 32, PC width carried for ROB lookup
DEPTH, 2, entries per source FIFO (power of two, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
flush  in  1  ROB flush; discard all buffered results
req_valid  in  4  per-source result valid; index 0=ALU, 1=LOAD, 2=MUL, 3=DIV
req_phy  in  4*PHY_W  per-source destination tag, source i at [i*PHY_W +: PHY_W]
req_data  in  4*DATA_W  per-source result data, same packing
req_pc  in  4*PC_W  per-source instruction PC, same packing
req_ready  out  4  per-source FIFO can accept this cycle
cdb_valid  out  1  CDB beat valid
cdb_phy  out  PHY_W  broadcast destination tag
cdb_data  out  DATA_W  broadcast data
cdb_pc  out  PC_W  broadcast PC
cdb_src  out  2  index of granted source
busy  out  1  any FIFO non-empty

Behaviour:
- Reset (rst=0 at edge):
  - All FIFOs emptied; round-robin pointer rr=0.
  - cdb_valid=0; cdb_phy, cdb_data, cdb_pc, cdb_src = 0; busy=0.
  - req_ready=0 while rst=0.
- FIFOs:
  - req_ready[i] = rst & (count[i] < DEPTH).
  - Ready is computed from the registered count only; no same-cycle pop-credit, so a full FIFO shows ready=0 even in a cycle it is popped.
  - Push when req_valid[i] & req_ready[i]. A source must not assert valid with ready=0; if it does, the beat is dropped and the FIFO is unchanged.
  - Push with req_phy == 0 (x0 mapping): accepted (handshake completes) but not written to the FIFO; never broadcast.
  - Push and pop on the same FIFO in one cycle: both happen, count unchanged, FIFO order preserved.
  - Read/write pointers wrap modulo DEPTH.
- Arbitration (combinational on registered FIFO state):
  - Scan sources rr, rr+1, … (mod 4); grant the first non-empty FIFO and pop its head.
  - If no FIFO is non-empty: no grant, rr unchanged.
- Grant update (at the edge): rr ← (granted index + 1) mod 4.
- CDB output (registered):
  - On a grant, next edge: cdb_valid=1; cdb_phy/data/pc = popped entry; cdb_src = granted index.
  - With no grant: cdb_valid=0; cdb_phy/data/pc/src hold their last values.
- Latency: a result pushed at edge N is broadcast at the earliest after edge N+1, i.e. one cycle, when uncontended.
- Throughput: 1 CDB beat per cycle. Worst-case wait for a non-empty FIFO is 3 beats.
- busy = OR of (count[i] != 0), from registered state.
- Flush (rst=1, flush=1 at edge):
  - All FIFOs emptied; same-cycle pushes discarded; rr ← 0.
  - cdb_valid ← 0; no grant is made that cycle.
  - req_ready still follows the pre-flush counts in the flush cycle.
- Reset takes precedence over flush. Reset mid-operation discards all buffered entries with no broadcast.

Test Plan:
- Single result: reset, then ALU pushes phy=5, data=0x1234, pc=0x40 at edge 1 → cycle after edge 2: cdb_valid=1, phy=5, data=0x1234, pc=0x40, src=0; next cycle cdb_valid=0, outputs held.
- All four sources push once at the same edge with rr=0 → four consecutive beats with src 0,1,2,3, data intact; busy drops after the 4th pop.
- DIV pushes 3 back-to-back beats, DEPTH=2, no other traffic → ready=1 for the first 2 pushes; the 3rd is accepted only once count<2. Output order matches push order with no loss.
- Continuous traffic from MUL and LOAD → grants alternate 1,2,1,2. Neither source waits more than 1 beat between grants.
- Push with phy=0 from ALU → handshake completes, no CDB beat, busy stays 0.
- Fill ALU and MUL FIFOs, assert flush for 1 cycle together with a new LOAD push → cdb_valid=0 next cycle, busy=0, LOAD result never broadcast, rr=0.
